// File: rtl/serial_frame_receiver.sv
// serial_frame_receiver
//   Deserializes an MSB-first serial bit stream into WIDTH-bit words and
//   queues them in a two-entry buffer behind a valid/ready handshake.
//
// Ports
//   CLK          in   clock, all state updates on the rising edge
//   RST_n        in   asynchronous active-low reset
//   Serial_IN    in   serial data bit, MSB first
//   Shift_En     in   qualifies Serial_IN as a valid bit this cycle
//   Frame_Start  in   current qualified bit is the MSB of a new word
//   OUT          out  head word of the buffer (reads 0 after reset)
//   OUT_Valid    out  buffer holds at least one word
//   OUT_Ready    in   consumer accepts the head word
//   Overflow     out  sticky: a completed word was dropped (buffer full)
//   Frame_Err    out  one-cycle pulse: a partial word was discarded
//   Dbg_State    out  shift FSM state (0 = IDLE, 1 = SHIFT)
//
// Handshake: a word transfers on every rising edge where OUT_Valid=1 and
// OUT_Ready=1. OUT is held stable while OUT_Valid=1 and OUT_Ready=0.
module serial_frame_receiver #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
) (
  input  logic             CLK,
  input  logic             RST_n,
  input  logic             Serial_IN,
  input  logic             Shift_En,
  input  logic             Frame_Start,
  output logic [WIDTH-1:0] OUT,
  output logic             OUT_Valid,
  input  logic             OUT_Ready,
  output logic             Overflow,
  output logic             Frame_Err,
  output logic             Dbg_State
);

  localparam int CW    = $clog2(WIDTH);
  localparam int OCC_W = $clog2(DEPTH + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  // Only the WIDTH-1 bits received so far are kept; the final bit is
  // appended combinationally on the capturing edge.
  logic [WIDTH-2:0]   shreg_q, shreg_d;
  logic               ferr_q, ferr_d;

  logic [WIDTH-1:0]   buf0_q, buf0_d;   // head entry
  logic [WIDTH-1:0]   buf1_q, buf1_d;   // second entry
  logic [OCC_W-1:0]   occ_q, occ_d;
  logic               ovf_q, ovf_d;

  logic [WIDTH-1:0]   shifted;
  logic               push;
  logic               pop;

  // ---------------------------------------------------------------------
  // Shift FSM: next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    ferr_d  = 1'b0;
    push    = 1'b0;
    shifted = {shreg_q, Serial_IN};

    if (Shift_En) begin
      if (Frame_Start) begin
        // The first bit lands in the low position; after WIDTH-1 further
        // shifts it sits at bit WIDTH-1 of the completed word.
        shreg_d    = '0;
        shreg_d[0] = Serial_IN;
        cnt_d      = CW'(1);
        state_d    = SHIFT;
        ferr_d     = (cnt_q != '0);
      end else if (cnt_q == CW'(WIDTH - 1)) begin
        push    = 1'b1;
        shreg_d = shifted[WIDTH-2:0];
        cnt_d   = '0;
        state_d = IDLE;
      end else begin
        shreg_d = shifted[WIDTH-2:0];
        cnt_d   = cnt_q + CW'(1);
        state_d = SHIFT;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Output buffer: two entries, head in buf0
  // ---------------------------------------------------------------------
  always_comb begin
    buf0_d = buf0_q;
    buf1_d = buf1_q;
    occ_d  = occ_q;
    ovf_d  = ovf_q;
    pop    = (occ_q != '0) && OUT_Ready;

    if (push && pop) begin
      // Occupancy unchanged; a pop frees room so a full buffer never drops.
      if (occ_q == OCC_W'(1)) begin
        buf0_d = shifted;
      end else begin
        buf0_d = buf1_q;
        buf1_d = shifted;
      end
    end else if (push) begin
      if (occ_q == '0) begin
        buf0_d = shifted;
        occ_d  = OCC_W'(1);
      end else if (occ_q == OCC_W'(1)) begin
        buf1_d = shifted;
        occ_d  = OCC_W'(2);
      end else begin
        ovf_d  = 1'b1;  // full, no pop: new word dropped, stored words kept
      end
    end else if (pop) begin
      buf0_d = buf1_q;
      occ_d  = occ_q - OCC_W'(1);
    end

    if (occ_q == OCC_W'(DEPTH) && push && !pop) begin
      ovf_d = 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
      ferr_q  <= 1'b0;
      buf0_q  <= '0;
      buf1_q  <= '0;
      occ_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      ferr_q  <= ferr_d;
      buf0_q  <= buf0_d;
      buf1_q  <= buf1_d;
      occ_q   <= occ_d;
      ovf_q   <= ovf_d;
    end
  end

  assign OUT       = buf0_q;
  assign OUT_Valid = (occ_q != '0);
  assign Overflow  = ovf_q;
  assign Frame_Err = ferr_q;
  assign Dbg_State = state_q;

endmodule
